// File: rtl/xbox_mem_arb.sv
// xbox_mem_arb: shares one XBOX memory port between NUM_REQ requesters.
// Round-robin by default; define XBOX_ARB_FIXED_PRIO_EN for fixed priority.
module xbox_mem_arb #(
    parameter int NUM_REQ            = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int MAX_BURST          = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_REQ-1:0]                           req_valid,
    input  logic [NUM_REQ-1:0]                           req_wr,
    input  logic [NUM_REQ-1:0]                           req_last,
    input  logic [NUM_REQ-1:0][LOG2_LINES_PER_MEM-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][7:0][31:0]                req_wdata,
    input  logic [NUM_REQ-1:0][31:0]                     req_be,
    output logic [NUM_REQ-1:0]                           req_ready,
    output logic [NUM_REQ-1:0]                           rsp_valid,
    output logic [7:0][31:0]                             rsp_rdata,
    output logic [LOG2_LINES_PER_MEM-1:0]                xlr_mem_addr,
    output logic [7:0][31:0]                             xlr_mem_wdata,
    output logic [31:0]                                  xlr_mem_be,
    output logic                                         xlr_mem_rd,
    output logic                                         xlr_mem_wr,
    input  logic [7:0][31:0]                             xlr_mem_rdata,
    output logic                                         busy
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_OWN  = 2'b01;

    logic [1:0]    state;
    logic [OW-1:0] owner;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_nxt;
    logic          rsp_pend;
    logic [OW-1:0] rsp_owner;
    logic          own_ok;
    logic          accept;
    logic          rel;
    logic          grant_found;
    logic [OW-1:0] grant_idx;

    // An out-of-range owner is treated as not owning the port.
    assign own_ok   = (state == S_OWN) && (int'(owner) < NUM_REQ);
    assign accept   = own_ok && req_valid[owner];
    assign beat_nxt = beat_cnt + BW'(1);
    assign rel      = accept &&
                      (req_last[owner] || (beat_nxt == BW'(MAX_BURST)));

`ifdef XBOX_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest valid index wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = OW'(i);
            end
        end
    end
`else
    logic [OW-1:0] rr_ptr;

    // Round-robin: first valid requester after the last owner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found &&
                req_valid[OW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = OW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Remember the releasing owner so it is searched last next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= OW'(NUM_REQ - 1);
        end else if (rel) begin
            rr_ptr <= owner;
        end
    end
`endif

    // Ownership FSM: grant in IDLE, lock the port until last/burst cap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    beat_cnt <= '0;
                    if (grant_found) begin
                        state <= S_OWN;
                        owner <= grant_idx;
                    end
                end
                S_OWN: begin
                    if (!own_ok) begin
                        state    <= S_IDLE;
                        owner    <= '0;
                        beat_cnt <= '0;
                    end else if (rel) begin
                        state    <= S_IDLE;
                        beat_cnt <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_nxt;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    owner    <= '0;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

    // Memory port mux: driven only on an accepted beat, zero otherwise.
    always_comb begin
        req_ready     = '0;
        busy          = own_ok;
        xlr_mem_addr  = '0;
        xlr_mem_wdata = '0;
        xlr_mem_be    = '0;
        xlr_mem_rd    = 1'b0;
        xlr_mem_wr    = 1'b0;
        if (own_ok) begin
            req_ready[owner] = 1'b1;
        end
        if (accept) begin
            xlr_mem_addr = req_addr[owner];
            if (req_wr[owner]) begin
                xlr_mem_wr    = 1'b1;
                xlr_mem_wdata = req_wdata[owner];
                xlr_mem_be    = req_be[owner];
            end else begin
                xlr_mem_rd = 1'b1;
            end
        end
    end

    // Track which requester the returning read line belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend  <= 1'b0;
            rsp_owner <= '0;
        end else begin
            rsp_pend <= xlr_mem_rd;
            if (xlr_mem_rd) begin
                rsp_owner <= owner;
            end
        end
    end

    // Response pulse and shared read-data bus, gated by the pending flag.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rsp_pend) begin
            rsp_valid[rsp_owner] = 1'b1;
            rsp_rdata            = xlr_mem_rdata;
        end
    end

endmodule

// File: tb/tb_xbox_mem_arb.sv
// tb_xbox_mem_arb: directed vectors for xbox_mem_arb (NUM_REQ=2).
// Expected values are hand-derived per cycle; memory is a small model.
module tb_xbox_mem_arb;

    logic                  clk;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0]            req_wr;
    logic [1:0]            req_last;
    logic [1:0][7:0]       req_addr;
    logic [1:0][7:0][31:0] req_wdata;
    logic [1:0][31:0]      req_be;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [7:0][31:0]      rsp_rdata;
    logic [7:0]            xlr_mem_addr;
    logic [7:0][31:0]      xlr_mem_wdata;
    logic [31:0]           xlr_mem_be;
    logic                  xlr_mem_rd;
    logic                  xlr_mem_wr;
    logic [7:0][31:0]      xlr_mem_rdata;
    logic                  busy;

    logic [7:0][31:0]      mem_q;
    logic [7:0][31:0]      wline;
    logic [1:0]            g [4];
    int                    n_vec;
    int                    n_err;

    xbox_mem_arb #(
        .NUM_REQ(2),
        .LOG2_LINES_PER_MEM(8),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_wr(req_wr),
        .req_last(req_last),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .xlr_mem_addr(xlr_mem_addr),
        .xlr_mem_wdata(xlr_mem_wdata),
        .xlr_mem_be(xlr_mem_be),
        .xlr_mem_rd(xlr_mem_rd),
        .xlr_mem_wr(xlr_mem_wr),
        .xlr_mem_rdata(xlr_mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0][31:0] line_of(input logic [7:0] a);
        logic [7:0][31:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = {8'hC3, a, 8'(k), 8'h3C};
        end
        return r;
    endfunction

    function automatic logic [7:0] ga(input logic [1:0] gr);
        return (gr == 2'b01) ? 8'h20 : 8'h30;
    endfunction

    // Memory model: line appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (xlr_mem_rd) begin
            mem_q <= line_of(xlr_mem_addr);
        end else begin
            mem_q <= {8{32'hDEADBEEF}};
        end
    end
    assign xlr_mem_rdata = mem_q;

    task automatic chk(
        input string        tag,
        input logic [255:0] got,
        input logic [255:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got %h want %h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic cyc(
        input logic [1:0] v,
        input logic [1:0] w,
        input logic [1:0] l,
        input logic [7:0] a0,
        input logic [7:0] a1,
        input logic [1:0] e_rdy,
        input logic       e_rd,
        input logic       e_wr,
        input logic [7:0] e_addr,
        input logic [1:0] e_rsp,
        input logic [7:0] e_ra
    );
        logic [7:0][31:0] e_wd;
        logic [7:0][31:0] e_rl;
        e_wd = e_wr ? wline : '0;
        e_rl = (e_rsp != 2'b00) ? line_of(e_ra) : '0;
        req_valid   = v;
        req_wr      = w;
        req_last    = l;
        req_addr[0] = a0;
        req_addr[1] = a1;
        @(negedge clk);
        chk("ready", req_ready, e_rdy);
        chk("rdy_1hot", $onehot0(req_ready), 1'b1);
        chk("busy", busy, |e_rdy);
        chk("mem_rd", xlr_mem_rd, e_rd);
        chk("mem_wr", xlr_mem_wr, e_wr);
        chk("addr", xlr_mem_addr, e_addr);
        chk("wdata", xlr_mem_wdata, e_wd);
        chk("be", xlr_mem_be, e_wr ? 32'hFFFF_FFFF : 32'h0);
        chk("rsp", rsp_valid, e_rsp);
        chk("rdata", rsp_rdata, e_rl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_last  = '0;
        req_addr  = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp", rsp_valid, 2'b00);
        chk("rst_rd", xlr_mem_rd, 1'b0);
        chk("rst_wr", xlr_mem_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", xlr_mem_addr, 8'h00);
        chk("rst_rdata", rsp_rdata, 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wline[k]        = 32'(k + 1);
            req_wdata[1][k] = 32'hBAD0_0000 | 32'(k);
        end
        req_wdata[0] = wline;
        req_be[0]    = 32'hFFFF_FFFF;
        req_be[1]    = 32'h0000_FFFF;
`ifdef XBOX_ARB_FIXED_PRIO_EN
        g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        // single read beat from requester 0
        do_reset();
        cyc(2'b01, 2'b00, 2'b01, 8'h05, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        cyc(2'b01, 2'b00, 2'b01, 8'h05, 8'h00,
            2'b01, 1, 0, 8'h05, 2'b00, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b01, 8'h05);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);

        // both requesting, single-beat bursts
        do_reset();
        cyc(2'b11, 2'b00, 2'b11, 8'h20, 8'h30,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 2'b00, 2'b11, 8'h20, 8'h30,
                g[k], 1, 0, ga(g[k]), 2'b00, 8'h00);
            if (k < 3) begin
                cyc(2'b11, 2'b00, 2'b11, 8'h20, 8'h30,
                    2'b00, 0, 0, 8'h00, g[k], ga(g[k]));
            end
        end
        cyc(2'b10, 2'b00, 2'b11, 8'h20, 8'h30,
            2'b00, 0, 0, 8'h00, g[3], ga(g[3]));
        cyc(2'b10, 2'b00, 2'b11, 8'h20, 8'h30,
            2'b10, 1, 0, 8'h30, 2'b00, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b10, 8'h30);

        // long burst from requester 1, capped at 4 beats
        do_reset();
        cyc(2'b10, 2'b00, 2'b00, 8'h00, 8'h10,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        cyc(2'b11, 2'b00, 2'b01, 8'h40, 8'h10,
            2'b10, 1, 0, 8'h10, 2'b00, 8'h00);
        cyc(2'b11, 2'b00, 2'b01, 8'h40, 8'h11,
            2'b10, 1, 0, 8'h11, 2'b10, 8'h10);
        cyc(2'b11, 2'b00, 2'b01, 8'h40, 8'h12,
            2'b10, 1, 0, 8'h12, 2'b10, 8'h11);
        cyc(2'b11, 2'b00, 2'b01, 8'h40, 8'h13,
            2'b10, 1, 0, 8'h13, 2'b10, 8'h12);
        cyc(2'b11, 2'b00, 2'b01, 8'h40, 8'h14,
            2'b00, 0, 0, 8'h00, 2'b10, 8'h13);
        cyc(2'b11, 2'b00, 2'b01, 8'h40, 8'h14,
            2'b01, 1, 0, 8'h40, 2'b00, 8'h00);
        cyc(2'b10, 2'b00, 2'b00, 8'h00, 8'h14,
            2'b00, 0, 0, 8'h00, 2'b01, 8'h40);
        cyc(2'b10, 2'b00, 2'b00, 8'h00, 8'h14,
            2'b10, 1, 0, 8'h14, 2'b00, 8'h00);
        cyc(2'b10, 2'b00, 2'b10, 8'h00, 8'h15,
            2'b10, 1, 0, 8'h15, 2'b10, 8'h14);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b10, 8'h15);

        // write beat from requester 0, no response
        do_reset();
        cyc(2'b01, 2'b01, 2'b01, 8'h01, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        cyc(2'b01, 2'b01, 2'b01, 8'h01, 8'h00,
            2'b01, 0, 1, 8'h01, 2'b00, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);

        // reset during an accepted read beat
        cyc(2'b01, 2'b00, 2'b00, 8'h07, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        rst = 1'b1;
        cyc(2'b01, 2'b00, 2'b00, 8'h07, 8'h00,
            2'b01, 1, 0, 8'h07, 2'b00, 8'h00);
        rst = 1'b0;
        cyc(2'b11, 2'b00, 2'b11, 8'h08, 8'h09,
            2'b00, 0, 0, 8'h00, 2'b00, 8'h00);
        cyc(2'b11, 2'b00, 2'b11, 8'h08, 8'h09,
            2'b01, 1, 0, 8'h08, 2'b00, 8'h00);
        cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00,
            2'b00, 0, 0, 8'h00, 2'b01, 8'h08);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
